baccarat_hand_datapath: RTL and testbench
=========================================

// Module: baccarat_hand_datapath
// PURPOSE
//  Card-holding datapath that answers the baccarat dealing FSM's load strobes.
//  - On each accepted strobe, registers the dealt card into one of six hand slots.
//  - Returns pscore, dscore and pcard3 to the FSM and drives card values to the displays.
//  - Checks the load sequence; optionally tracks deck depletion across hands.
// PARAMETERS
//  NUM_DECKS  1  decks in shoe; per-rank limit = 4*NUM_DECKS (used only with DECK_TRACK_EN)
// PORTS
//  slow_clock   in   1  rising-edge clock shared with the dealing FSM
//  resetb       in   1  asynchronous reset, active-low
//  new_card     in   4  card rank offered this cycle: 1=A, 2..10, 11=J, 12=Q, 13=K
//  load_pcard1  in   1  store new_card in player slot 1 (load_pcard2/3 same, slots 2/3)
//  load_pcard2  in   1
//  load_pcard3  in   1
//  load_dcard1  in   1  store new_card in dealer slot 1 (load_dcard2/3 same, slots 2/3)
//  load_dcard2  in   1
//  load_dcard3  in   1
//  new_hand     in   1  sync clear of hand slots, cards_dealt and proto_err
//  shuffle      in   1  sync clear of deck counters and deck_err
//  pcard1..3    out  4  player slot ranks; 0 = empty
//  dcard1..3    out  4  dealer slot ranks; 0 = empty
//  pcard3       out  4  same port as above; consumed by the FSM's third-card rule
//  pscore       out  4  player score, 0..9
//  dscore       out  4  dealer score, 0..9
//  cards_dealt  out  3  accepted loads this hand, 0..6
//  proto_err    out  1  sticky load-sequence violation
//  deck_err     out  1  sticky rank-over-limit flag
// BEHAVIOUR
//  - Reset: resetb low asynchronously sets every output and every internal counter to 0.
//  - Load: sampled on the slow_clock rising edge. Latency is 1 edge.
//    - The slot updates at that edge.
//    - Scores are combinational from the slots, so the FSM sees them before its next edge.
//  - Accept: a load is accepted only when all of these hold:
//    - exactly one strobe is high;
//    - the target slot is empty;
//    - new_card is in 1..13;
//    - the prerequisite slot is nonzero.
//  - Prerequisites:
//    - pcard1: none.
//    - dcard1 needs pcard1.
//    - pcard2 needs dcard1.
//    - dcard2 needs pcard2.
//    - pcard3 needs dcard2.
//    - dcard3 needs dcard2 (dealer may draw without a player third card).
//  - Accepted load: write the slot; cards_dealt += 1. cards_dealt cannot exceed 6 because slots are write-once.
//  - Rejected load (strobe high but not accepted): no slot or count change; proto_err <= 1.
//  - No strobe: hold all state.
//  - Card value: rank 1..9 gives its face value; rank 10..13 gives 0.
//    - Score = (v1+v2+v3) mod 10.
//    - Use a 5-bit intermediate sum (max 27); empty slots count as 0.
//  - new_hand:
//    - Clears all slots, cards_dealt and proto_err at the edge.
//    - Takes priority over any strobe in the same cycle; that load is dropped and not flagged.
//    - Does not touch deck state.
//  - Reset mid-hand: immediate full clear.
//    - A load strobe present while resetb is low, or on the releasing edge, is ignored.
// CONFIGURATION
//  - DECK_TRACK_EN defined:
//    - 13 rank counters, each $clog2(4*NUM_DECKS+1) bits.
//    - Each accepted load increments counter[rank].
//    - If the counter is already at 4*NUM_DECKS, the load is still accepted, the counter holds, and deck_err <= 1.
//    - shuffle clears the counters and deck_err at the edge.
//    - shuffle concurrent with a load: the clear wins; that card is not counted.
//  - DECK_TRACK_EN undefined:
//    - No counters; deck_err tied 0; shuffle ignored; NUM_DECKS unused.
// TESTING
//  1 Natural: reset, then load pcard1=9, dcard1=13, pcard2=12, dcard2=8
//    -> pscore=9, dscore=8, cards_dealt=4, proto_err=0.
//  2 Third card, mod-10 wrap: pcard1=7, dcard1=1, pcard2=6, dcard2=2, pcard3=5, dcard3=4
//    -> pscore=8, dscore=7, pcard3=5, cards_dealt=6.
//  3 Sequence error: load_pcard1 and load_dcard1 high together, then load_pcard2 before dcard1, then a reload of pcard1
//    -> slots unchanged each time, proto_err=1; new_hand -> proto_err=0, all slots 0.
//  4 Bad card: load_pcard1 with new_card=14, then with 0
//    -> pcard1 stays 0, proto_err=1, cards_dealt=0.
//  5 Mid-hand reset: deal 3 cards, pulse resetb low between edges
//    -> all outputs 0 immediately; the next load_pcard1 is accepted normally.
//  6 DECK_TRACK_EN, NUM_DECKS=1: deal rank 1 as pcard1 in 5 hands, separated by new_hand
//    -> deck_err=0 after the 4th deal, 1 after the 5th; shuffle -> deck_err=0.

Source files
------------

// File: rtl/baccarat_hand_datapath.sv
// Baccarat hand datapath: write-once card slots, scores and load-order checks.
// Optional shoe depletion tracking is enabled by defining DECK_TRACK_EN.
module baccarat_hand_datapath #(
  parameter int NUM_DECKS = 1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       new_hand,
  input  logic       shuffle,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic       proto_err,
  output logic       deck_err
);

  // slot order: 0=p1 1=p2 2=p3 3=d1 4=d2 5=d3
  logic [5:0][3:0] slot_q, slot_d;
  logic [2:0]      dealt_q, dealt_d;
  logic            perr_q, perr_d;

  logic [5:0] ld;
  logic [5:0] pre_ok;
  logic [5:0] empty;
  logic       one_hot;
  logic       card_ok;
  logic       accept;

  function automatic logic [4:0] card_val(input logic [3:0] r);
    card_val = (r <= 4'd9) ? {1'b0, r} : 5'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] m;
    m = s;
    if (m >= 5'd20)
      m = m - 5'd20;
    else if (m >= 5'd10)
      m = m - 5'd10;
    mod10 = m[3:0];
  endfunction

  always_comb begin
    ld = {load_dcard3, load_dcard2, load_dcard1,
          load_pcard3, load_pcard2, load_pcard1};
    one_hot = (ld != 6'd0) && ((ld & (ld - 6'd1)) == 6'd0);
    card_ok = (new_card >= 4'd1) && (new_card <= 4'd13);
    for (int i = 0; i < 6; i++)
      empty[i] = (slot_q[i] == 4'd0);
    pre_ok[0] = 1'b1;
    pre_ok[1] = !empty[3];
    pre_ok[2] = !empty[4];
    pre_ok[3] = !empty[0];
    pre_ok[4] = !empty[1];
    // dealer may draw a third card whether or not the player did
    pre_ok[5] = !empty[4];
    accept = one_hot && card_ok && |(ld & pre_ok & empty);
  end

  always_comb begin
    slot_d  = slot_q;
    dealt_d = dealt_q;
    perr_d  = perr_q;
    if (new_hand) begin
      slot_d  = '0;
      dealt_d = 3'd0;
      perr_d  = 1'b0;
    end else if (accept) begin
      for (int i = 0; i < 6; i++)
        if (ld[i])
          slot_d[i] = new_card;
      dealt_d = dealt_q + 3'd1;
    end else if (|ld) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slot_q  <= '0;
      dealt_q <= 3'd0;
      perr_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      dealt_q <= dealt_d;
      perr_q  <= perr_d;
    end
  end

  logic [4:0] psum, dsum;

  always_comb begin
    psum = card_val(slot_q[0]) + card_val(slot_q[1])
         + card_val(slot_q[2]);
    dsum = card_val(slot_q[3]) + card_val(slot_q[4])
         + card_val(slot_q[5]);
  end

  assign pcard1      = slot_q[0];
  assign pcard2      = slot_q[1];
  assign pcard3      = slot_q[2];
  assign dcard1      = slot_q[3];
  assign dcard2      = slot_q[4];
  assign dcard3      = slot_q[5];
  assign pscore      = mod10(psum);
  assign dscore      = mod10(dsum);
  assign cards_dealt = dealt_q;
  assign proto_err   = perr_q;

`ifdef DECK_TRACK_EN
  localparam int LIMIT = 4 * NUM_DECKS;
  localparam int CW    = $clog2(LIMIT + 1);

  logic [12:0][CW-1:0] cnt_q, cnt_d;
  logic                derr_q, derr_d;

  always_comb begin
    cnt_d  = cnt_q;
    derr_d = derr_q;
    if (shuffle) begin
      cnt_d  = '0;
      derr_d = 1'b0;
    end else if (accept && !new_hand) begin
      for (int r = 0; r < 13; r++) begin
        if (new_card == 4'(r + 1)) begin
          // over-limit card is still dealt; only the flag records it
          if (cnt_q[r] == CW'(LIMIT))
            derr_d = 1'b1;
          else
            cnt_d[r] = cnt_q[r] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q  <= '0;
      derr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      derr_q <= derr_d;
    end
  end

  assign deck_err = derr_q;
`else
  localparam int unused_num_decks = NUM_DECKS;
  logic unused_shuffle;
  assign unused_shuffle = shuffle;
  assign deck_err       = 1'b0;
`endif

endmodule

// File: tb/tb_baccarat_hand_datapath.sv
// Bench for baccarat_hand_datapath: directed vector table, reset and deck
// corner sequences, then random loads against a rule-level hand model.
module tb_baccarat_hand_datapath;

  localparam int ND    = 1;
  localparam int LIMIT = 4 * ND;

  logic       clk;
  logic       rst_n;
  logic [3:0] card;
  logic [5:0] ld;
  logic       nh;
  logic       sh;
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
  logic [3:0] ps, ds;
  logic [2:0] dealt;
  logic       perr, derr;

  int n_chk;
  int n_fail;

  baccarat_hand_datapath #(.NUM_DECKS(ND)) dut (
    .slow_clock  (clk),
    .resetb      (rst_n),
    .new_card    (card),
    .load_pcard1 (ld[0]),
    .load_pcard2 (ld[1]),
    .load_pcard3 (ld[2]),
    .load_dcard1 (ld[3]),
    .load_dcard2 (ld[4]),
    .load_dcard3 (ld[5]),
    .new_hand    (nh),
    .shuffle     (sh),
    .pcard1      (pc1),
    .pcard2      (pc2),
    .pcard3      (pc3),
    .dcard1      (dc1),
    .dcard2      (dc2),
    .dcard3      (dc3),
    .pscore      (ps),
    .dscore      (ds),
    .cards_dealt (dealt),
    .proto_err   (perr),
    .deck_err    (derr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: index 0=p1 1=p2 2=p3 3=d1 4=d2 5=d3
  int m_slot[6];
  int m_dealt;
  bit m_perr;
  bit m_derr;
  int m_cnt[14];
  int need[6] = '{-1, 3, 4, 0, 1, 4};

  function automatic int val(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic int m_pscore();
    return (val(m_slot[0]) + val(m_slot[1]) + val(m_slot[2])) % 10;
  endfunction

  function automatic int m_dscore();
    return (val(m_slot[3]) + val(m_slot[4]) + val(m_slot[5])) % 10;
  endfunction

  function automatic bit legal(input int i);
    return m_slot[i] == 0 && (need[i] < 0 || m_slot[need[i]] != 0);
  endfunction

  task automatic m_reset();
    foreach (m_slot[i]) m_slot[i] = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_dealt = 0;
    m_perr  = 0;
    m_derr  = 0;
  endtask

  task automatic m_step(input logic [5:0] l, input int c,
                        input bit h, input bit s);
    int n;
    int t;
    bit acc;
    n   = 0;
    t   = 0;
    acc = 0;
    for (int i = 0; i < 6; i++)
      if (l[i]) begin
        n++;
        t = i;
      end
    if (h) begin
      foreach (m_slot[i]) m_slot[i] = 0;
      m_dealt = 0;
      m_perr  = 0;
    end else if (n > 0) begin
      if (n == 1 && c >= 1 && c <= 13 && legal(t)) begin
        m_slot[t] = c;
        m_dealt++;
        acc = 1;
      end else
        m_perr = 1;
    end
`ifdef DECK_TRACK_EN
    if (s) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_derr = 0;
    end else if (acc) begin
      if (m_cnt[c] == LIMIT) m_derr = 1;
      else m_cnt[c]++;
    end
`endif
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " pcard1"}, pc1, m_slot[0]);
    chk({tag, " pcard2"}, pc2, m_slot[1]);
    chk({tag, " pcard3"}, pc3, m_slot[2]);
    chk({tag, " dcard1"}, dc1, m_slot[3]);
    chk({tag, " dcard2"}, dc2, m_slot[4]);
    chk({tag, " dcard3"}, dc3, m_slot[5]);
    chk({tag, " pscore"}, ps, m_pscore());
    chk({tag, " dscore"}, ds, m_dscore());
    chk({tag, " cards_dealt"}, dealt, m_dealt);
    chk({tag, " proto_err"}, perr, m_perr);
    chk({tag, " deck_err"}, derr, m_derr);
  endtask

  // one clock: drive after negedge, release and update model after posedge
  task automatic step(input logic [5:0] l, input logic [3:0] c,
                      input bit h, input bit s);
    @(negedge clk);
    ld   = l;
    card = c;
    nh   = h;
    sh   = s;
    @(posedge clk);
    #1;
    ld = '0;
    nh = 1'b0;
    sh = 1'b0;
    m_step(l, int'(c), h, s);
  endtask

  typedef struct {
    string      nm;
    logic [5:0] l;
    logic [3:0] c;
    bit         h;
    int         e_ps;
    int         e_ds;
    int         e_p3;
    int         e_dealt;
    bit         e_perr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    ld     = '0;
    card   = 4'd0;
    nh     = 1'b0;
    sh     = 1'b0;
    m_reset();

    tbl.push_back('{"nat p1=9",   6'b000001, 4'd9,  0, 9, 0, 0, 1, 0});
    tbl.push_back('{"nat d1=K",   6'b001000, 4'd13, 0, 9, 0, 0, 2, 0});
    tbl.push_back('{"nat p2=Q",   6'b000010, 4'd12, 0, 9, 0, 0, 3, 0});
    tbl.push_back('{"nat d2=8",   6'b010000, 4'd8,  0, 9, 8, 0, 4, 0});
    tbl.push_back('{"nh1",        6'b000000, 4'd0,  1, 0, 0, 0, 0, 0});
    tbl.push_back('{"tc p1=7",    6'b000001, 4'd7,  0, 7, 0, 0, 1, 0});
    tbl.push_back('{"tc d1=A",    6'b001000, 4'd1,  0, 7, 1, 0, 2, 0});
    tbl.push_back('{"tc p2=6",    6'b000010, 4'd6,  0, 3, 1, 0, 3, 0});
    tbl.push_back('{"tc d2=2",    6'b010000, 4'd2,  0, 3, 3, 0, 4, 0});
    tbl.push_back('{"tc p3=5",    6'b000100, 4'd5,  0, 8, 3, 5, 5, 0});
    tbl.push_back('{"tc d3=4",    6'b100000, 4'd4,  0, 8, 7, 5, 6, 0});
    tbl.push_back('{"nh2",        6'b000000, 4'd0,  1, 0, 0, 0, 0, 0});
    tbl.push_back('{"se p1+d1",   6'b001001, 4'd5,  0, 0, 0, 0, 0, 1});
    tbl.push_back('{"se p2 early",6'b000010, 4'd5,  0, 0, 0, 0, 0, 1});
    tbl.push_back('{"se p1=5",    6'b000001, 4'd5,  0, 5, 0, 0, 1, 1});
    tbl.push_back('{"se reload",  6'b000001, 4'd3,  0, 5, 0, 0, 1, 1});
    tbl.push_back('{"nh3",        6'b000000, 4'd0,  1, 0, 0, 0, 0, 0});
    tbl.push_back('{"bad 14",     6'b000001, 4'd14, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{"bad 0",      6'b000001, 4'd0,  0, 0, 0, 0, 0, 1});
    tbl.push_back('{"nh+load",    6'b000001, 4'd9,  1, 0, 0, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].l, tbl[i].c, tbl[i].h, 1'b0);
      chk({tbl[i].nm, " pscore"}, ps, tbl[i].e_ps);
      chk({tbl[i].nm, " dscore"}, ds, tbl[i].e_ds);
      chk({tbl[i].nm, " pcard3"}, pc3, tbl[i].e_p3);
      chk({tbl[i].nm, " dealt"}, dealt, tbl[i].e_dealt);
      chk({tbl[i].nm, " perr"}, perr, tbl[i].e_perr);
    end
    chk_model("after table");

    // mid-hand asynchronous reset
    step(6'b000001, 4'd2, 0, 0);
    step(6'b001000, 4'd3, 0, 0);
    step(6'b000010, 4'd4, 0, 0);
    chk("pre-rst dealt", dealt, 3);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk_model("mid rst");
    #1 rst_n = 1'b1;
    step(6'b000001, 4'd4, 0, 0);
    chk("post-rst pcard1", pc1, 4);
    chk("post-rst dealt", dealt, 1);
    chk("post-rst perr", perr, 0);

`ifdef DECK_TRACK_EN
    step(6'b000000, 4'd0, 1, 1);
    for (int h = 1; h <= 5; h++) begin
      step(6'b000001, 4'd1, 0, 0);
      chk($sformatf("deck ace %0d", h), derr, (h == 5) ? 1 : 0);
      chk($sformatf("deck ace %0d p1", h), pc1, 1);
      step(6'b000000, 4'd0, 1, 0);
    end
    step(6'b000001, 4'd1, 0, 1);
    chk("shuffle+load derr", derr, 0);
    chk("shuffle+load p1", pc1, 1);
    chk_model("deck");
`endif

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] l;
      logic [3:0] c;
      int q[$];
      int r;
      bit h;
      bit s;
      l = '0;
      r = $urandom_range(0, 99);
      q.delete();
      for (int i = 0; i < 6; i++)
        if (legal(i)) q.push_back(i);
      if (r < 55 && q.size() > 0)
        l[q[$urandom_range(0, q.size() - 1)]] = 1'b1;
      else if (r < 80)
        l[$urandom_range(0, 5)] = 1'b1;
      else if (r < 88)
        l = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 9)
        c = 4'($urandom_range(1, 13));
      else
        c = 4'($urandom_range(0, 15));
      h = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 19) == 0);
      step(l, c, h, s);
      if (n % 20 == 19)
        chk_model($sformatf("rnd %0d", n));
      else begin
        chk("rnd pscore", ps, m_pscore());
        chk("rnd dscore", ds, m_dscore());
        chk("rnd dealt", dealt, m_dealt);
        chk("rnd perr", perr, m_perr);
        chk("rnd derr", derr, m_derr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
